// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial frame deserializer driving one-hot config write strobes
module config_loader #(
    parameter int NUM_TARGETS = 4,
    parameter int ADDR_W      = 8,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [31:0]            config_data,
    output logic [NUM_TARGETS-1:0] config_en,
    output logic                   busy,
    output logic [CNT_W-1:0]       frame_count,
    output logic [CNT_W-1:0]       err_count,
    output logic                   err_flag
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        PAR    = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam logic [31:0] NUM_T = 32'(NUM_TARGETS);

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        bit_cnt;
    logic [ADDR_W-1:0] addr_sr;
    logic [31:0]       data_sr;
    logic              accept;
    logic              last_addr;
    logic              last_data;
    logic              commit_go;
    logic              parity_ok;
    logic              addr_ok;

    assign bit_ready = (state_q != COMMIT);
    assign busy      = (state_q != IDLE);
    assign accept    = bit_valid && bit_ready;
    assign last_addr = (bit_cnt == 6'(ADDR_W - 1));
    assign last_data = (bit_cnt == 6'd31);
    assign commit_go = (state_q == PAR) && accept;

    // Even parity over address, data and the incoming parity bit.
    assign parity_ok = ~((^addr_sr) ^ (^data_sr) ^ bit_in);
    assign addr_ok   = ({{(32-ADDR_W){1'b0}}, addr_sr} < NUM_T);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && bit_in)    state_d = ADDR;
            ADDR:    if (accept && last_addr) state_d = DATA;
            DATA:    if (accept && last_data) state_d = PAR;
            PAR:     if (accept)              state_d = COMMIT;
            COMMIT:                           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            addr_sr <= '0;
            data_sr <= '0;
        end else begin
            if (state_q != state_d) begin
                bit_cnt <= '0;
            end else if (accept && (state_q == ADDR || state_q == DATA)) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
            if (accept && state_q == ADDR) begin
                addr_sr <= ADDR_W'({addr_sr, bit_in});
            end
            if (accept && state_q == DATA) begin
                data_sr <= {data_sr[30:0], bit_in};
            end
        end
    end

    // Strobe defaults low every cycle so it lives only for the COMMIT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            config_data <= '0;
            config_en   <= '0;
            frame_count <= '0;
            err_count   <= '0;
            err_flag    <= 1'b0;
        end else begin
            config_en <= '0;
            if (commit_go) begin
                if (parity_ok && addr_ok) begin
                    config_data <= data_sr;
                    config_en   <= NUM_TARGETS'(1) << addr_sr;
                    if (frame_count != '1) begin
                        frame_count <= frame_count + CNT_W'(1);
                    end
                end else begin
                    err_flag <= 1'b1;
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// tb/tb_config_loader.sv - scoreboard bench for config_loader
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_ready;
    logic [31:0] config_data;
    logic [3:0]  config_en;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] err_count;
    logic        err_flag;

    config_loader #(.NUM_TARGETS(4), .ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .config_data(config_data), .config_en(config_en),
        .busy(busy), .frame_count(frame_count), .err_count(err_count),
        .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  en;
        logic [31:0] data;
        logic [15:0] fc;
        logic [15:0] ec;
        logic        ef;
        logic        lat_chk;
        int          start_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_data;
    logic [15:0] m_fc;
    logic [15:0] m_ec;
    logic        m_ef;
    logic        post_commit = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every COMMIT cycle (bit_ready low) pops one expected frame result.
    always @(negedge clk) begin
        if (!reset) begin
            post_commit = 1'b0;
        end else begin
            if (post_commit) begin
                check("strobe_one_cycle", {60'd0, config_en}, 64'd0);
                check("busy_after_commit", {63'd0, busy}, 64'd0);
            end
            post_commit = 1'b0;
            if (!bit_ready) begin
                post_commit = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_commit", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("config_en", {60'd0, config_en}, {60'd0, e.en});
                    check("config_data", {32'd0, config_data}, {32'd0, e.data});
                    check("frame_count", {48'd0, frame_count}, {48'd0, e.fc});
                    check("err_count", {48'd0, err_count}, {48'd0, e.ec});
                    check("err_flag", {63'd0, err_flag}, {63'd0, e.ef});
                    check("busy_in_commit", {63'd0, busy}, 64'd1);
                    if (e.lat_chk) begin
                        check("latency", 64'(cyc - e.start_cyc), 64'd41);
                    end
                end
            end else if (config_en !== 4'd0) begin
                check("spurious_strobe", {60'd0, config_en}, 64'd0);
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        bit_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_data = '0;
        m_fc = '0;
        m_ec = '0;
        m_ef = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic gap, output int stalls, output int acc_cyc);
        stalls = 0;
        if (gap && $urandom_range(0, 1) == 1) begin
            @(negedge clk);
            bit_valid = 1'b0;
            bit_in = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in = b;
        while (!bit_ready && stalls < 10) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 10) check("ready_timeout", 64'd1, 64'd0);
        acc_cyc = cyc + 1;
    endtask

    // Sends lead zeros, then up to nbits of frame (start bit included); pushes the
    // expected result once the start bit is accepted when a full frame is sent.
    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic bad_par,
                              input logic gap, input int lead, input int nbits,
                              input logic [3:0] exp_en, input logic lat, output int start_stalls);
        logic [40:0] pay;
        logic        p;
        int          st;
        int          ac;
        exp_t        e;
        p = (^a) ^ (^d) ^ bad_par;
        pay = {a, d, p};
        for (int i = 0; i < lead; i++) send_bit(1'b0, gap, st, ac);
        send_bit(1'b1, gap, start_stalls, ac);
        if (nbits == 42) begin
            if (exp_en != 4'd0) begin
                m_data = d;
                m_fc = m_fc + 16'd1;
            end else begin
                m_ec = m_ec + 16'd1;
                m_ef = 1'b1;
            end
            e.en = exp_en; e.data = m_data; e.fc = m_fc; e.ec = m_ec; e.ef = m_ef;
            e.lat_chk = lat; e.start_cyc = ac;
            sb_q.push_back(e);
        end
        for (int i = 40; i > 41 - nbits; i--) send_bit(pay[i], gap, st, ac);
    endtask

    task automatic go_idle();
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 64'd1, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int st;
        apply_reset();
        check("rst_config_data", {32'd0, config_data}, 64'd0);
        check("rst_config_en", {60'd0, config_en}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_bit_ready", {63'd0, bit_ready}, 64'd1);
        check("rst_frame_count", {48'd0, frame_count}, 64'd0);
        check("rst_err_count", {48'd0, err_count}, 64'd0);
        check("rst_err_flag", {63'd0, err_flag}, 64'd0);

        // Good frame to target 1, continuous valid
        send_frame(8'h01, 32'hA5A5_0F0F, 1'b0, 1'b0, 0, 42, 4'b0010, 1'b1, st);
        go_idle(); drain();

        // Parity error
        apply_reset();
        send_frame(8'h01, 32'hA5A5_0F0F, 1'b1, 1'b0, 0, 42, 4'b0000, 1'b1, st);
        go_idle(); drain();
        check("bad_par_data_held", {32'd0, config_data}, 64'd0);

        // Out-of-range address, then highest valid address
        apply_reset();
        send_frame(8'h04, 32'h0000_0000, 1'b0, 1'b0, 0, 42, 4'b0000, 1'b1, st);
        go_idle(); drain();
        send_frame(8'h03, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 42, 4'b1000, 1'b1, st);
        go_idle(); drain();

        // Random gaps and leading idle zeros
        apply_reset();
        send_frame(8'h01, 32'hA5A5_0F0F, 1'b0, 1'b1, 5, 42, 4'b0010, 1'b0, st);
        go_idle(); drain();

        // Reset mid-frame
        apply_reset();
        send_frame(8'h02, 32'h1234_5678, 1'b0, 1'b0, 0, 20, 4'b0000, 1'b0, st);
        @(posedge clk);
        #2;
        reset = 1'b0;
        bit_valid = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_config_en", {60'd0, config_en}, 64'd0);
        check("abort_bit_ready", {63'd0, bit_ready}, 64'd1);
        check("abort_data", {32'd0, config_data}, 64'd0);
        apply_reset();
        send_frame(8'h02, 32'h1234_5678, 1'b0, 1'b0, 0, 42, 4'b0100, 1'b1, st);
        go_idle(); drain();

        // Back-to-back: second start bit offered during COMMIT must stall once
        apply_reset();
        send_frame(8'h00, 32'h0000_0001, 1'b0, 1'b0, 0, 42, 4'b0001, 1'b1, st);
        send_frame(8'h01, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 42, 4'b0010, 1'b1, st);
        check("b2b_start_stall", 64'(st), 64'd1);
        go_idle(); drain();
        check("b2b_frame_count", {48'd0, frame_count}, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1);
    end

endmodule
